// File: rtl/unet_ctrl_pkg.sv
// Shared constants for the UNet sequencer: host status codes, state encoding
// and the buffer address-width helper.
package unet_ctrl_pkg;

    localparam logic [2:0] CTRL_CALC         = 3'd0;
    localparam logic [2:0] CTRL_SEND_WEIGHTS = 3'd1;
    localparam logic [2:0] CTRL_SEND_DATA    = 3'd2;
    localparam logic [2:0] CTRL_DATA_READY   = 3'd3;
    localparam logic [2:0] CTRL_IDLE         = 3'd4;
    localparam logic [2:0] CTRL_ERROR        = 3'd5;

    // State codes equal the host status codes so ctrl is a plain copy of state.
    localparam logic [2:0] S_CALC         = CTRL_CALC;
    localparam logic [2:0] S_SEND_WEIGHTS = CTRL_SEND_WEIGHTS;
    localparam logic [2:0] S_SEND_DATA    = CTRL_SEND_DATA;
    localparam logic [2:0] S_DATA_READY   = CTRL_DATA_READY;
    localparam logic [2:0] S_IDLE         = CTRL_IDLE;
    localparam logic [2:0] S_ERROR        = CTRL_ERROR;

    function automatic int unet_aw_min(input int n_layers, input int wpl,
                                       input int data_words, input int result_words);
        int m;
        m = n_layers * wpl;
        if (data_words > m) m = data_words;
        if (result_words > m) m = result_words;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/unet_word_counter.sv
// Up-counter with synchronous clear (used on state entry), load and
// terminal-count compare against a caller-supplied value.
module unet_word_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk) begin
        if (rst)      cnt <= '0;
        else if (clr) cnt <= '0;
        else if (ld)  cnt <= ld_val;
        else if (inc) cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/unet_seq_ctrl.sv
// UNet accelerator sequencer: frame load, per-layer weight load + compute, result drain.
// Optional CALC watchdog enabled by defining UNET_CTRL_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | waiting for start
// SEND_DATA    | writing input activations to the activation buffer
// SEND_WEIGHTS | writing this layer's weights to the weight buffer
// CALC         | core kicked, waiting for core_done
// DATA_READY   | streaming results to the host
// ERROR        | watchdog expired, left only through rst
module unet_seq_ctrl
    import unet_ctrl_pkg::*;
#(
    parameter int DW           = 32,
    parameter int N_LAYERS     = 4,
    parameter int WPL          = 256,
    parameter int DATA_WORDS   = 1024,
    parameter int RESULT_WORDS = 1024,
    parameter int AW           = 16,
    localparam int LW          = $clog2(N_LAYERS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          reuse_weights,
    input  logic [DW-1:0] data_in,
    input  logic          data_in_valid,
    output logic [2:0]    ctrl,
    output logic          busy,
    output logic [DW-1:0] data_out,
    output logic          data_out_valid,
    input  logic          data_out_ready,
    output logic [LW-1:0] layer_idx,
    output logic          mem_we,
    output logic          mem_sel,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          core_start,
    input  logic          core_done,
    output logic [AW-1:0] res_addr,
    input  logic [DW-1:0] res_rdata,
    output logic          error
);

    if (AW < unet_aw_min(N_LAYERS, WPL, DATA_WORDS, RESULT_WORDS)) begin : g_aw_check
        $error("unet_seq_ctrl: AW too small for buffer depth");
    end

    logic [2:0]    state, state_nx;
    logic          reuse_eff, weights_cached, calc_first;
    logic          wr, xfer, entry, wd_expire;
    logic [AW-1:0] cnt, cnt_tc_val;
    logic          cnt_tc;
    logic [LW-1:0] layer;
    logic          layer_tc, layer_clr, layer_inc;

    assign wr   = (state == S_SEND_DATA || state == S_SEND_WEIGHTS) && data_in_valid;
    assign xfer = (state == S_DATA_READY) && data_out_ready;

    always_comb begin
        cnt_tc_val = AW'(RESULT_WORDS - 1);
        case (state)
            S_SEND_DATA:    cnt_tc_val = AW'(DATA_WORDS - 1);
            S_SEND_WEIGHTS: cnt_tc_val = AW'(WPL - 1);
            default:        cnt_tc_val = AW'(RESULT_WORDS - 1);
        endcase
    end

`ifdef UNET_CTRL_TIMEOUT_EN
    logic [23:0] wd;

    always_ff @(posedge clk) begin
        if (rst || state != S_CALC || core_done) wd <= '0;
        else                                     wd <= wd + 1'b1;
    end

    // Fires on the (2^24-1)th consecutive CALC cycle without core_done.
    assign wd_expire = (state == S_CALC) && !core_done && (wd == 24'hFF_FFFE);
    assign error     = (state == S_ERROR);
`else
    assign wd_expire = 1'b0;
    assign error     = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        layer_clr = 1'b0;
        layer_inc = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx  = S_SEND_DATA;
                    layer_clr = 1'b1;
                end
            end
            S_SEND_DATA: begin
                if (wr && cnt_tc) state_nx = reuse_eff ? S_CALC : S_SEND_WEIGHTS;
            end
            S_SEND_WEIGHTS: begin
                if (wr && cnt_tc) state_nx = S_CALC;
            end
            S_CALC: begin
                if (core_done) begin
                    if (layer_tc) begin
                        state_nx = S_DATA_READY;
                    end else begin
                        layer_inc = 1'b1;
                        state_nx  = reuse_eff ? S_CALC : S_SEND_WEIGHTS;
                    end
                end else if (wd_expire) begin
                    state_nx = S_ERROR;
                end
            end
            S_DATA_READY: begin
                if (xfer && cnt_tc) state_nx = S_IDLE;
            end
            S_ERROR: state_nx = S_ERROR;
            default: state_nx = S_IDLE;
        endcase
    end

    // CALC->CALC on a reused-weights layer advance counts as a fresh entry.
    assign entry = (state_nx != state) || (state == S_CALC && core_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            reuse_eff      <= 1'b0;
            weights_cached <= 1'b0;
            calc_first     <= 1'b0;
        end else begin
            state      <= state_nx;
            calc_first <= entry && (state_nx == S_CALC);
            if (state == S_IDLE && start)
                reuse_eff <= reuse_weights & weights_cached;
            if (state == S_CALC && core_done && layer_tc)
                weights_cached <= 1'b1;
        end
    end

    unet_word_counter #(.W(AW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (entry),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (wr || xfer),
        .tc_val (cnt_tc_val),
        .cnt    (cnt),
        .tc     (cnt_tc)
    );

    unet_word_counter #(.W(LW)) u_layer (
        .clk    (clk),
        .rst    (rst),
        .clr    (layer_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (layer_inc),
        .tc_val (LW'(N_LAYERS - 1)),
        .cnt    (layer),
        .tc     (layer_tc)
    );

    assign ctrl           = state;
    assign busy           = (state != S_IDLE);
    assign layer_idx      = layer;
    assign core_start     = (state == S_CALC) && calc_first;
    assign mem_we         = wr;
    assign mem_sel        = wr && (state == S_SEND_DATA);
    assign mem_wdata      = wr ? data_in : '0;
    assign data_out_valid = (state == S_DATA_READY);
    assign data_out       = data_out_valid ? res_rdata : '0;
    assign res_addr       = data_out_valid ? cnt : '0;

    always_comb begin
        mem_addr = '0;
        if (wr) begin
            if (state == S_SEND_DATA) mem_addr = cnt;
            else                      mem_addr = AW'(layer) * AW'(WPL) + cnt;
        end
    end

endmodule
